// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared state, grant and SRAM strobe encodings for the memory
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IACC  = 2'd1,
    DACC  = 2'd2,
    RECOV = 2'd3
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } sram_ctrl_t;

  localparam sram_ctrl_t SRAM_CTRL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};

endpackage

`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
// ============================================================================
// Module      : sram_port_arbiter_if
// Description : Fetch/data request buses and SRAM pins of the port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_port_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_kill;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_ready;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ready;
  logic                  mem_stall;
  logic [ADDR_W-1:0]     sram_addr;
  logic [DATA_W-1:0]     sram_wdata;
  logic [DATA_W-1:0]     sram_rdata;
  logic                  sram_ce_n;
  logic                  sram_oe_n;
  logic                  sram_we_n;
  logic [DATA_W/8-1:0]   sram_be_n;

  // Pipeline stages and the SRAM device together form the master side.
  modport master (
    output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, d_be, sram_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_stall,
           sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  modport slave (
    input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, d_be, sram_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_stall,
           sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

endinterface

`default_nettype wire

// File: rtl/sram_acc_timer.sv
// ============================================================================
// Module      : sram_acc_timer
// Description : Loadable down-counter with zero flag; times SRAM strobe and
//               write-recovery windows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_acc_timer #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         load,
  input  wire logic [W-1:0] load_val,
  output logic              zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one asynchronous SRAM port between fetch and data
//               stages with alternating priority and registered strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 32,
  parameter int ACC_CYC  = 2,
  parameter int WR_RECOV = 1
) (
  input wire logic            clk,
  input wire logic            rst,
  sram_port_arbiter_if.slave  bus
);

  localparam int       BE_W        = DATA_W / 8;
  localparam bit       c_has_recov = (WR_RECOV > 0);
  localparam logic [3:0] c_acc_load = 4'(ACC_CYC - 1);
  localparam logic [3:0] c_rec_load = 4'(c_has_recov ? WR_RECOV - 1 : 0);

  arb_state_t          r_state;
  grant_t              r_last_grant;
  logic                r_kill_pend;
  logic                r_is_store;
  sram_ctrl_t          r_ctrl;
  logic [BE_W-1:0]     r_be_n;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_ready;
  logic                r_d_ready;

  logic                w_if_cand;
  logic                w_d_cand;
  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_acc_done;
  logic                w_tmr_load;
  logic [3:0]          w_tmr_val;
  logic                w_tmr_zero;

  // A completion cycle is a bus turnaround: nobody is granted while a ready
  // pulse is out, which gives one access per ACC_CYC+2 cycles.
  always_comb begin
    w_if_cand  = bus.if_req & ~bus.if_kill & ~r_if_ready;
    w_d_cand   = bus.d_req & ~r_d_ready;
    w_grant_d  = (r_state == IDLE) & ~(r_if_ready | r_d_ready) & w_d_cand &
                 (~w_if_cand | (r_last_grant == FETCH));
    w_grant_i  = (r_state == IDLE) & ~(r_if_ready | r_d_ready) & w_if_cand & ~w_grant_d;
    w_acc_done = ((r_state == IACC) | (r_state == DACC)) & w_tmr_zero;
    w_tmr_load = w_grant_d | w_grant_i | (w_acc_done & r_is_store & c_has_recov);
    w_tmr_val  = (r_state == IDLE) ? c_acc_load : c_rec_load;
  end

  sram_acc_timer #(.W(4)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= FETCH;
      r_kill_pend  <= 1'b0;
      r_is_store   <= 1'b0;
      r_ctrl       <= SRAM_CTRL_IDLE;
      r_be_n       <= '1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_ready   <= 1'b0;
      r_d_ready    <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state      <= DACC;
            r_last_grant <= DATA;
            r_addr       <= bus.d_addr;
            r_is_store   <= bus.d_we;
            r_ctrl.ce_n  <= 1'b0;
            if (bus.d_we) begin
              r_ctrl.we_n <= 1'b0;
              r_be_n      <= ~bus.d_be;
              r_wdata     <= bus.d_wdata;
            end else begin
              r_ctrl.oe_n <= 1'b0;
              r_be_n      <= '0;
            end
          end else if (w_grant_i) begin
            r_state      <= IACC;
            r_last_grant <= FETCH;
            r_addr       <= bus.if_addr;
            r_is_store   <= 1'b0;
            r_kill_pend  <= 1'b0;
            r_ctrl.ce_n  <= 1'b0;
            r_ctrl.oe_n  <= 1'b0;
            r_be_n       <= '0;
          end
        end
        IACC: begin
          if (bus.if_kill) begin
            r_kill_pend <= 1'b1;
          end
          // A killed fetch still completes its full SRAM cycle; only the
          // ready pulse is withheld.
          if (w_tmr_zero) begin
            r_if_rdata  <= bus.sram_rdata;
            r_if_ready  <= ~(r_kill_pend | bus.if_kill);
            r_kill_pend <= 1'b0;
            r_ctrl      <= SRAM_CTRL_IDLE;
            r_be_n      <= '1;
            r_state     <= IDLE;
          end
        end
        DACC: begin
          if (w_tmr_zero) begin
            if (!r_is_store) begin
              r_d_rdata <= bus.sram_rdata;
            end
            r_d_ready <= 1'b1;
            r_ctrl    <= SRAM_CTRL_IDLE;
            r_be_n    <= '1;
            r_state   <= (r_is_store && c_has_recov) ? RECOV : IDLE;
          end
        end
        RECOV: begin
          if (w_tmr_zero) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata   = r_if_rdata;
  assign bus.if_ready   = r_if_ready;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.d_ready    = r_d_ready;
  assign bus.sram_addr  = r_addr;
  assign bus.sram_wdata = r_wdata;
  assign bus.sram_ce_n  = r_ctrl.ce_n;
  assign bus.sram_oe_n  = r_ctrl.oe_n;
  assign bus.sram_we_n  = r_ctrl.we_n;
  assign bus.sram_be_n  = r_be_n;
  assign bus.mem_stall  = (bus.if_req & ~r_if_ready) | (bus.d_req & ~r_d_ready);

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Directed self-checking bench for sram_port_arbiter with a
//               small byte-writable SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem [16];

  sram_port_arbiter_if #(.ADDR_W(18), .DATA_W(32)) bus ();

  sram_port_arbiter #(
    .ADDR_W   (18),
    .DATA_W   (32),
    .ACC_CYC  (2),
    .WR_RECOV (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word i preset to byte i repeated, word 0 holds an instruction.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= {4{4'(i), 4'(i)}};
      end
      mem[0] <= 32'h8C22_0004;
    end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
      for (int b = 0; b < 4; b++) begin
        if (!bus.sram_be_n[b]) mem[bus.sram_addr[3:0]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end
    end
  end

  assign bus.sram_rdata = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr[3:0]] : 32'h0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n} !== 3'b111) begin errors++; $display("FAIL reset_strobes got %b exp 111", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}); end
    checks++; if (bus.sram_be_n !== 4'hF) begin errors++; $display("FAIL reset_be_n got %h exp f", bus.sram_be_n); end
    checks++; if (bus.sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.sram_addr); end
    checks++; if (bus.sram_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", bus.sram_wdata); end
    checks++; if ({bus.if_ready, bus.d_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {bus.if_ready, bus.d_ready}); end
    checks++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {bus.if_rdata, bus.d_rdata}); end
    checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.mem_stall); end
  endtask

  task automatic test_single_fetch;
    bus.if_req = 1'b1; bus.if_addr = 18'h00100;
    tick;
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n} !== 3'b001) begin errors++; $display("FAIL fetch_strobes_c1 got %b exp 001", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}); end
    checks++; if (bus.sram_be_n !== 4'h0) begin errors++; $display("FAIL fetch_be_c1 got %h exp 0", bus.sram_be_n); end
    checks++; if (bus.sram_addr !== 18'h00100) begin errors++; $display("FAIL fetch_addr_c1 got %h exp 00100", bus.sram_addr); end
    checks++; if (bus.mem_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c1 got %b exp 1", bus.mem_stall); end
    tick;
    checks++; if (bus.sram_oe_n !== 1'b0 || bus.if_ready !== 1'b0) begin errors++; $display("FAIL fetch_c2 oe_n %b ready %b exp 0 0", bus.sram_oe_n, bus.if_ready); end
    tick;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready_c3 got %b exp 1", bus.if_ready); end
    checks++; if (bus.if_rdata !== 32'h8C22_0004) begin errors++; $display("FAIL fetch_rdata got %h exp 8c220004", bus.if_rdata); end
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n} !== 2'b11) begin errors++; $display("FAIL fetch_release_c3 got %b exp 11", {bus.sram_ce_n, bus.sram_oe_n}); end
    bus.if_req = 1'b0;
    tick;
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_c4 got %b exp 0", bus.if_ready); end
  endtask

  task automatic test_back_to_back;
    logic exp_d;
    logic exp_i;
    bus.if_req = 1'b1; bus.if_addr = 18'h1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 18'h2;
    tick;
    checks++; if (bus.sram_addr !== 18'h2 || bus.sram_oe_n !== 1'b0) begin errors++; $display("FAIL arb_data_first addr %h oe_n %b exp 2 0", bus.sram_addr, bus.sram_oe_n); end
    tick; tick;
    checks++; if ({bus.d_ready, bus.if_ready} !== 2'b10) begin errors++; $display("FAIL arb_d_ready_c3 got %b exp 10", {bus.d_ready, bus.if_ready}); end
    checks++; if (bus.d_rdata !== 32'h2222_2222) begin errors++; $display("FAIL arb_d_rdata got %h exp 22222222", bus.d_rdata); end
    bus.d_req = 1'b0;
    tick;
    checks++; if (bus.sram_oe_n !== 1'b1) begin errors++; $display("FAIL arb_turnaround_c4 oe_n got %b exp 1", bus.sram_oe_n); end
    tick;
    checks++; if (bus.sram_addr !== 18'h1 || bus.sram_oe_n !== 1'b0) begin errors++; $display("FAIL arb_fetch_second addr %h oe_n %b exp 1 0", bus.sram_addr, bus.sram_oe_n); end
    tick; tick;
    checks++; if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h1111_1111) begin errors++; $display("FAIL arb_if_ready_c7 ready %b rdata %h exp 1 11111111", bus.if_ready, bus.if_rdata); end
    bus.if_req = 1'b0;
    tick;
    // Both requesters held continuously: grants must alternate data/fetch.
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick;
      exp_d = (k == 3) || (k == 11);
      exp_i = (k == 7) || (k == 15);
      checks++; if ({bus.d_ready, bus.if_ready} !== {exp_d, exp_i}) begin errors++; $display("FAIL alternate_k%0d ready d/i got %b exp %b", k, {bus.d_ready, bus.if_ready}, {exp_d, exp_i}); end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick;
  endtask

  task automatic test_store;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 18'h3;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
    tick;
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n} !== 3'b010) begin errors++; $display("FAIL store_strobes_c1 got %b exp 010", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}); end
    checks++; if (bus.sram_be_n !== 4'b1100) begin errors++; $display("FAIL store_be_n got %b exp 1100", bus.sram_be_n); end
    checks++; if (bus.sram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_wdata got %h exp deadbeef", bus.sram_wdata); end
    bus.d_addr = 18'h5; bus.d_wdata = 32'h0; bus.d_be = 4'hF;
    tick;
    checks++; if (bus.sram_we_n !== 1'b0 || bus.sram_addr !== 18'h3 || bus.sram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_latched_c2 we_n %b addr %h wdata %h exp 0 3 deadbeef", bus.sram_we_n, bus.sram_addr, bus.sram_wdata); end
    tick;
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL store_ready_c3 got %b exp 1", bus.d_ready); end
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n} !== 7'h7F) begin errors++; $display("FAIL store_recov_strobes got %h exp 7f", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n}); end
    checks++; if (bus.sram_addr !== 18'h3 || bus.sram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_recov_hold addr %h wdata %h exp 3 deadbeef", bus.sram_addr, bus.sram_wdata); end
    checks++; if (bus.d_rdata !== 32'h2222_2222) begin errors++; $display("FAIL store_d_rdata_kept got %h exp 22222222", bus.d_rdata); end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 18'h3;
    tick;
    checks++; if (bus.sram_ce_n !== 1'b1) begin errors++; $display("FAIL store_idle_c4 ce_n got %b exp 1", bus.sram_ce_n); end
    tick;
    checks++; if (bus.sram_oe_n !== 1'b0 || bus.sram_addr !== 18'h3) begin errors++; $display("FAIL store_readback_c5 oe_n %b addr %h exp 0 3", bus.sram_oe_n, bus.sram_addr); end
    tick; tick;
    checks++; if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h3333_BEEF) begin errors++; $display("FAIL store_readback ready %b rdata %h exp 1 3333beef", bus.if_ready, bus.if_rdata); end
    bus.if_req = 1'b0;
    tick;
  endtask

  task automatic test_if_kill;
    bus.if_req = 1'b1; bus.if_addr = 18'h1; bus.if_kill = 1'b1;
    tick;
    checks++; if (bus.sram_ce_n !== 1'b1) begin errors++; $display("FAIL kill_idle_no_grant ce_n got %b exp 1", bus.sram_ce_n); end
    bus.if_kill = 1'b0;
    tick;
    checks++; if (bus.sram_oe_n !== 1'b0) begin errors++; $display("FAIL kill_iacc_c1 oe_n got %b exp 0", bus.sram_oe_n); end
    bus.if_kill = 1'b1;
    tick;
    checks++; if (bus.sram_oe_n !== 1'b0) begin errors++; $display("FAIL kill_full_access_c2 oe_n got %b exp 0", bus.sram_oe_n); end
    bus.if_kill = 1'b0; bus.if_req = 1'b0;
    tick;
    checks++; if (bus.if_ready !== 1'b0 || bus.sram_oe_n !== 1'b1) begin errors++; $display("FAIL kill_c3 ready %b oe_n %b exp 0 1", bus.if_ready, bus.sram_oe_n); end
    tick;
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL kill_c4 ready got %b exp 0", bus.if_ready); end
    bus.if_req = 1'b1; bus.if_addr = 18'h2;
    tick;
    checks++; if (bus.sram_oe_n !== 1'b0 || bus.sram_addr !== 18'h2) begin errors++; $display("FAIL kill_next_grant oe_n %b addr %h exp 0 2", bus.sram_oe_n, bus.sram_addr); end
    tick; tick;
    checks++; if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h2222_2222) begin errors++; $display("FAIL kill_next_ready ready %b rdata %h exp 1 22222222", bus.if_ready, bus.if_rdata); end
    bus.if_req = 1'b0;
    tick;
  endtask

  task automatic test_mem_stall;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 18'h2;
    #1;
    checks++; if (bus.mem_stall !== 1'b1) begin errors++; $display("FAIL stall_c0 got %b exp 1", bus.mem_stall); end
    for (int k = 1; k <= 2; k++) begin
      tick;
      checks++; if (bus.mem_stall !== 1'b1) begin errors++; $display("FAIL stall_c%0d got %b exp 1", k, bus.mem_stall); end
    end
    tick;
    checks++; if (bus.d_ready !== 1'b1 || bus.mem_stall !== 1'b0) begin errors++; $display("FAIL stall_c3 ready %b stall %b exp 1 0", bus.d_ready, bus.mem_stall); end
    bus.d_req = 1'b0;
    tick;
    checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL stall_c4 got %b exp 0", bus.mem_stall); end
  endtask

  task automatic test_async_reset;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 18'h4;
    bus.d_wdata = 32'hCAFE_F00D; bus.d_be = 4'hF;
    tick;
    checks++; if (bus.sram_we_n !== 1'b0) begin errors++; $display("FAIL arst_pre_we_n got %b exp 0", bus.sram_we_n); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n} !== 3'b111) begin errors++; $display("FAIL arst_strobes got %b exp 111", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}); end
    checks++; if (bus.sram_be_n !== 4'hF || bus.sram_addr !== 18'h0 || bus.sram_wdata !== 32'h0) begin errors++; $display("FAIL arst_bus be_n %h addr %h wdata %h exp f 0 0", bus.sram_be_n, bus.sram_addr, bus.sram_wdata); end
    checks++; if ({bus.d_ready, bus.if_ready} !== 2'b00 || {bus.d_rdata, bus.if_rdata} !== 64'h0) begin errors++; $display("FAIL arst_outputs ready %b rdata %h exp 00 0", {bus.d_ready, bus.if_ready}, {bus.d_rdata, bus.if_rdata}); end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (bus.d_ready !== 1'b0 || bus.sram_ce_n !== 1'b1) begin errors++; $display("FAIL arst_after_%0d ready %b ce_n %b exp 0 1", k, bus.d_ready, bus.sram_ce_n); end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.if_kill = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    test_single_fetch;
    test_back_to_back;
    test_store;
    test_if_kill;
    test_mem_stall;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single asynchronous SRAM port between instruction fetch (read-only) and the data stage (loads and stores), and sequences SRAM chip, output and write strobes.
- Issues one access at a time, holds address, data and strobes stable for a fixed access time, registers read data, and returns a one-cycle ready pulse to the requester.
- Sits between the IF/MEM pipeline stages and the SRAM pins. It replaces the decode-stage single-cycle load wait with a real wait/stall handshake.

Parameters:
- ADDR_W, 18: SRAM word-address width.
- DATA_W, 32: SRAM data width. Byte lanes = DATA_W/8.
- ACC_CYC, 2: cycles the strobes are held per access. Legal range 1..15.
- WR_RECOV, 1: idle cycles after a write before the next access. Legal range 0..3.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- if_req, input, 1: fetch request, level, held until if_ready.
- if_addr, input, ADDR_W: fetch word address.
- if_kill, input, 1: discard the in-flight or pending fetch (branch stomp).
- if_rdata, output, DATA_W: fetched word, valid while if_ready is high.
- if_ready, output, 1: one-cycle completion pulse for fetch.
- d_req, input, 1: data request, level, held until d_ready.
- d_we, input, 1: 1 = store, 0 = load.
- d_addr, input, ADDR_W: data word address.
- d_wdata, input, DATA_W: store data.
- d_be, input, DATA_W/8: active-high store byte enables.
- d_rdata, output, DATA_W: load data, valid while d_ready is high.
- d_ready, output, 1: one-cycle completion pulse for data.
- mem_stall, output, 1: pipeline stall request.
- sram_addr, output, ADDR_W: SRAM address.
- sram_wdata, output, DATA_W: SRAM write data.
- sram_rdata, input, DATA_W: SRAM read data.
- sram_ce_n, output, 1: chip enable, active low.
- sram_oe_n, output, 1: output enable, active low.
- sram_we_n, output, 1: write enable, active low.
- sram_be_n, output, DATA_W/8: byte enables, active low.

Behaviour:
- Reset values:
  - state = IDLE; sram_ce_n = sram_oe_n = sram_we_n = 1; sram_be_n = all ones; sram_addr = 0; sram_wdata = 0.
  - if_ready = d_ready = 0; if_rdata = d_rdata = 0; last_grant = FETCH; kill_pend = 0.
- States: IDLE, IACC, DACC, RECOV. All outputs are registered.
- IDLE arbitration, evaluated each cycle:
  - A requester whose ready is high this cycle is ignored.
  - Only d_req valid: go to DACC. Only if_req valid (and if_kill low): go to IACC.
  - Both valid: data wins, unless last_grant = DATA, in which case fetch wins. Alternation prevents starvation.
- At grant (IDLE -> xACC edge):
  - Latch the address, plus wdata and be for stores. Drive sram_ce_n = 0 and load the access counter with ACC_CYC-1.
  - Fetch or load: sram_oe_n = 0, sram_be_n = all zeros.
  - Store: sram_we_n = 0, sram_be_n = ~d_be.
- xACC:
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture sram_rdata into if_rdata or d_rdata (reads), and release all strobes to 1 on the next edge.
  - Next state: RECOV if the access was a store and WR_RECOV > 0, otherwise IDLE.
  - The matching ready pulses for exactly one cycle after that capture edge.
- Latency: request seen in IDLE at cycle n, ready high at cycle n+ACC_CYC+1. Back-to-back throughput: one access per ACC_CYC+2 cycles, plus WR_RECOV after stores.
- RECOV: strobes inactive, sram_addr and sram_wdata held. Lasts WR_RECOV cycles, then IDLE.
- if_kill:
  - In IDLE: if_req is not granted that cycle.
  - During IACC: the SRAM access runs to completion (timing is never truncated), kill_pend is set, and if_ready is suppressed for that access.
  - Has no effect on data accesses.
- mem_stall = (if_req & ~if_ready) | (d_req & ~d_ready). Combinational from inputs and registered ready.
- Store data is never returned on d_rdata; d_rdata holds its prior value.
- Request inputs changing while the requester is granted and busy are ignored: latched values are used.
- Asynchronous reset mid-access: strobes deassert immediately and the in-flight store may be partial. No ready is produced for the aborted access.

Decomposition:
- Shared package mips_mem_pkg holds:
  - State encodings: IDLE = 2'd0, IACC = 2'd1, DACC = 2'd2, RECOV = 2'd3.
  - Grant encodings: FETCH / DATA.
  - SRAM_CTRL_IDLE constant: ce/oe/we all 1.
- One natural sub-module: sram_acc_timer, a loadable down-counter with a zero flag, used for both ACC_CYC and WR_RECOV.

Test Plan:
- Single fetch, ACC_CYC = 2, if_addr = 0x00100, SRAM model returns 0x8C220004 -> sram_oe_n low for 2 cycles, if_ready high at cycle 3 after the request, if_rdata = 0x8C220004.
- Simultaneous if_req and d_req load at reset (last_grant = FETCH) -> data granted first, d_ready at +3, fetch granted next, if_ready at +7. Repeat with both continuously requesting -> grants strictly alternate.
- Store d_addr = 0x3, d_wdata = 0xDEADBEEF, d_be = 4'b0011, WR_RECOV = 1 -> sram_we_n low 2 cycles, sram_be_n = 4'b1100, one RECOV cycle with all strobes high, then IDLE.
- if_kill pulsed 1 cycle into IACC -> SRAM strobes still last ACC_CYC cycles, if_ready never asserts, next if_req granted normally.
- Async rst asserted mid-DACC store -> ce/we/oe go high within the same cycle, d_ready stays 0, all outputs at reset values.
- mem_stall check: d_req held 4 cycles -> mem_stall high until the d_ready cycle, low the cycle after the request drops.
